// File: rtl/mem_pkg.sv
// Shared definitions for the multi-lane data memory: control-field layout,
// access-size encodings, clear-sequencer states and per-lane decode helpers.
package mem_pkg;

    localparam int MC_STORE = 3;
    localparam int MC_LOAD  = 2;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Byte-enable mask of an access; the reserved size 2'b11 behaves as a word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
            SZ_BYTE: be = 4'b0001 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_HALF: mis = off[0];
            SZ_BYTE: mis = 1'b0;
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte or half from a 32-bit word and sign/zero extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Select the sub-word field and apply the requested extension.
    always_comb begin
        half_s = offset[1] ? word[31:16] : word[15:0];
        byte_s = word[{offset, 3'b000} +: 8];
        case (size)
            SZ_HALF: result = uns ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SZ_BYTE: result = uns ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_multilane.sv
// Multi-lane M-stage data memory: program-ordered byte stores, in-bundle
// store-to-load forwarding, misalignment flags and a reset-time clear sequencer.
module dmem_multilane
    import mem_pkg::*;
#(
    parameter int NLANE          = 2,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NLANE*32-1:0]  aluout_m,
    input  logic [NLANE*32-1:0]  writedata_m,
    input  logic [NLANE*4-1:0]   mem_ctrl_m,
    input  logic [NLANE-1:0]     mem_uns_m,
    output logic [NLANE*32-1:0]  readdata_m,
    output logic [NLANE-1:0]     misalign_m,
    output logic                 mem_busy
);

    localparam int IDXW = $clog2(DEPTH);

    logic [31:0]      mem_r [DEPTH];
    state_t           state_r;
    logic [IDXW-1:0]  clr_cnt_r;
    logic [NLANE*32-1:0] readdata_r;
    logic [NLANE-1:0]    misalign_r;

    logic [IDXW-1:0] idx_s     [NLANE];
    logic [1:0]      off_s     [NLANE];
    logic [1:0]      size_s    [NLANE];
    logic            st_s      [NLANE];
    logic            ld_s      [NLANE];
    logic            mis_s     [NLANE];
    logic [3:0]      be_s      [NLANE];
    logic [31:0]     wdat_s    [NLANE];
    logic [31:0]     fwd_s     [NLANE];
    logic [31:0]     aligned_s [NLANE];

    // Per-lane request decode: store dominates load, misaligned stores lose their enables.
    always_comb begin
        for (int k = 0; k < NLANE; k++) begin
            idx_s[k]  = aluout_m[32*k+2 +: IDXW];
            off_s[k]  = aluout_m[32*k +: 2];
            size_s[k] = mem_ctrl_m[4*k +: 2];
            st_s[k]   = mem_ctrl_m[4*k+MC_STORE];
            ld_s[k]   = mem_ctrl_m[4*k+MC_LOAD] & ~mem_ctrl_m[4*k+MC_STORE];
            mis_s[k]  = (st_s[k] | ld_s[k]) & is_misaligned(size_s[k], off_s[k]);
            be_s[k]   = (st_s[k] && !mis_s[k]) ? byte_enable(size_s[k], off_s[k]) : 4'b0000;
            case (size_s[k])
                SZ_BYTE: wdat_s[k] = {4{writedata_m[32*k +: 8]}};
                SZ_HALF: wdat_s[k] = {2{writedata_m[32*k +: 16]}};
                default: wdat_s[k] = writedata_m[32*k +: 32];
            endcase
        end
    end

    // Load view: pre-write array word with older lanes' same-cycle store bytes merged in order.
    always_comb begin
        for (int k = 0; k < NLANE; k++) begin
            fwd_s[k] = mem_r[idx_s[k]];
            for (int j = 0; j < NLANE; j++) begin
                for (int b = 0; b < 4; b++) begin
                    fwd_s[k][8*b +: 8] = ((j < k) && be_s[j][b] && (idx_s[j] == idx_s[k]))
                                         ? wdat_s[j][8*b +: 8] : fwd_s[k][8*b +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_align
        load_align u_align (
            .word   (fwd_s[g]),
            .offset (off_s[g]),
            .size   (size_s[g]),
            .uns    (mem_uns_m[g]),
            .result (aligned_s[g])
        );
    end

    // Clear sequencer: walks every word once after reset, then stays in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_r <= {IDXW{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + IDXW'(1);
                    if (clr_cnt_r == IDXW'(DEPTH - 1)) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN:  state_r <= ST_RUN;
                default: state_r <= ST_CLEAR;
            endcase
        end
    end

    // Array write port: clear word during CLEAR, otherwise lane stores with the youngest lane last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_cnt_r] <= 32'h0000_0000;
            end else begin
                for (int k = 0; k < NLANE; k++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_s[k][b]) begin
                            mem_r[idx_s[k]][8*b +: 8] <= wdat_s[k][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Registered load results and misalignment flags, forced to zero while clearing.
    always_ff @(posedge clk) begin
        if (reset || (state_r == ST_CLEAR)) begin
            readdata_r <= {(NLANE*32){1'b0}};
            misalign_r <= {NLANE{1'b0}};
        end else begin
            for (int k = 0; k < NLANE; k++) begin
                readdata_r[32*k +: 32] <= (ld_s[k] && !mis_s[k]) ? aligned_s[k] : 32'h0000_0000;
                misalign_r[k]          <= mis_s[k];
            end
        end
    end

    assign readdata_m = readdata_r;
    assign misalign_m = misalign_r;
    assign mem_busy   = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_dmem_multilane.sv
// Directed self-checking bench for dmem_multilane with two lanes and a 16-word array.
module tb_dmem_multilane;

    localparam int NLANE = 2;
    localparam int DEPTH = 16;

    localparam logic [3:0] ST_W = 4'b1000;
    localparam logic [3:0] ST_B = 4'b1010;
    localparam logic [3:0] LD_W = 4'b0100;
    localparam logic [3:0] LD_H = 4'b0101;
    localparam logic [3:0] LD_B = 4'b0110;
    localparam logic [3:0] IDLE = 4'b0000;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NLANE*32-1:0] aluout_m = '0;
    logic [NLANE*32-1:0] writedata_m = '0;
    logic [NLANE*4-1:0]  mem_ctrl_m = '0;
    logic [NLANE-1:0]    mem_uns_m = '0;
    logic [NLANE*32-1:0] readdata_m;
    logic [NLANE-1:0]    misalign_m;
    logic                mem_busy;

    int checks = 0;
    int errors = 0;

    dmem_multilane #(.NLANE(NLANE), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .aluout_m    (aluout_m),
        .writedata_m (writedata_m),
        .mem_ctrl_m  (mem_ctrl_m),
        .mem_uns_m   (mem_uns_m),
        .readdata_m  (readdata_m),
        .misalign_m  (misalign_m),
        .mem_busy    (mem_busy)
    );

    always #5 clk = ~clk;

    task automatic set_lane(input int k, input logic [3:0] ctrl, input logic [31:0] addr,
                            input logic [31:0] data, input logic uns);
        mem_ctrl_m[4*k +: 4]    = ctrl;
        aluout_m[32*k +: 32]    = addr;
        writedata_m[32*k +: 32] = data;
        mem_uns_m[k]            = uns;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NLANE; k++) set_lane(k, IDLE, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cyc;
        idle_all();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (mem_busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b expected 1", mem_busy);
        end
        checks++;
        if (readdata_m !== 64'h0 || misalign_m !== 2'b00) begin
            errors++; $display("FAIL reset_outputs: got rd=%h mis=%b expected 0/00", readdata_m, misalign_m);
        end
        reset = 1'b0;
        cyc = 0;
        set_lane(0, LD_W, 32'h0000_0000, 32'h0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            step();
            cyc = i;
            if (i == 3) begin
                checks++;
                if (readdata_m[31:0] !== 32'h0) begin
                    errors++; $display("FAIL busy_load: got %h expected 00000000", readdata_m[31:0]);
                end
            end
            if (mem_busy !== 1'b1) break;
        end
        checks++;
        if (cyc != DEPTH) begin
            errors++; $display("FAIL clear_len: got %0d cycles expected %0d", cyc, DEPTH);
        end
        set_lane(0, LD_W, 32'h0000_003C, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'h0) begin
            errors++; $display("FAIL cleared_3c: got %h expected 00000000", readdata_m[31:0]);
        end
        idle_all();
    endtask

    task automatic test_store_load();
        set_lane(0, ST_W, 32'h0000_0008, 32'd30, 1'b0);
        step();
        idle_all();
        set_lane(1, LD_W, 32'h0000_0008, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[63:32] !== 32'd30) begin
            errors++; $display("FAIL load_8: got %h expected %h", readdata_m[63:32], 32'd30);
        end
        checks++;
        if (readdata_m[31:0] !== 32'h0 || misalign_m !== 2'b00) begin
            errors++; $display("FAIL idle_lane0: got rd=%h mis=%b expected 0/00", readdata_m[31:0], misalign_m);
        end
        set_lane(1, LD_W, 32'h0000_0048, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[63:32] !== 32'd30) begin
            errors++; $display("FAIL load_wrap48: got %h expected %h", readdata_m[63:32], 32'd30);
        end
        idle_all();
    endtask

    task automatic test_subword();
        set_lane(0, ST_B, 32'h0000_0021, 32'h0000_0080, 1'b0);
        step();
        set_lane(0, LD_B, 32'h0000_0021, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL byte_signed: got %h expected FFFFFF80", readdata_m[31:0]);
        end
        set_lane(0, LD_B, 32'h0000_0021, 32'h0, 1'b1);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'h0000_0080) begin
            errors++; $display("FAIL byte_unsigned: got %h expected 00000080", readdata_m[31:0]);
        end
        set_lane(0, LD_W, 32'h0000_0020, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'h0000_8000) begin
            errors++; $display("FAIL word_20: got %h expected 00008000", readdata_m[31:0]);
        end
        idle_all();
    endtask

    task automatic test_conflicts();
        set_lane(0, ST_W, 32'h0000_0004, 32'd2, 1'b0);
        set_lane(1, ST_W, 32'h0000_0004, 32'd4, 1'b0);
        step();
        idle_all();
        set_lane(0, LD_W, 32'h0000_0004, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'd4) begin
            errors++; $display("FAIL lane_priority: got %h expected %h", readdata_m[31:0], 32'd4);
        end
        set_lane(0, ST_W, 32'h0000_000C, 32'h0000_0011, 1'b0);
        set_lane(1, LD_W, 32'h0000_000C, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[63:32] !== 32'h0000_0011) begin
            errors++; $display("FAIL forward: got %h expected 00000011", readdata_m[63:32]);
        end
        set_lane(0, LD_W, 32'h0000_000C, 32'h0, 1'b0);
        set_lane(1, ST_W, 32'h0000_000C, 32'h0000_0022, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'h0000_0011) begin
            errors++; $display("FAIL no_backward_fwd: got %h expected 00000011", readdata_m[31:0]);
        end
        idle_all();
        set_lane(0, LD_W, 32'h0000_000C, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'h0000_0022) begin
            errors++; $display("FAIL young_store: got %h expected 00000022", readdata_m[31:0]);
        end
        idle_all();
    endtask

    task automatic test_misalign();
        set_lane(1, ST_W, 32'h0000_000D, 32'd400, 1'b0);
        step();
        checks++;
        if (misalign_m !== 2'b10) begin
            errors++; $display("FAIL mis_store: got %b expected 10", misalign_m);
        end
        idle_all();
        set_lane(0, LD_W, 32'h0000_000C, 32'h0, 1'b0);
        step();
        checks++;
        if (misalign_m !== 2'b00 || readdata_m[31:0] !== 32'h0000_0022) begin
            errors++; $display("FAIL mis_nowrite: got rd=%h mis=%b expected 00000022/00", readdata_m[31:0], misalign_m);
        end
        set_lane(0, ST_W, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        step();
        set_lane(0, LD_H, 32'h0000_0003, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'h0 || misalign_m !== 2'b01) begin
            errors++; $display("FAIL mis_load: got rd=%h mis=%b expected 00000000/01", readdata_m[31:0], misalign_m);
        end
        set_lane(0, LD_H, 32'h0000_0002, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'hFFFF_DEAD || misalign_m !== 2'b00) begin
            errors++; $display("FAIL half_hi: got rd=%h mis=%b expected FFFFDEAD/00", readdata_m[31:0], misalign_m);
        end
        idle_all();
    endtask

    task automatic test_reset_midclear();
        int cyc;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (7) step();
        checks++;
        if (mem_busy !== 1'b1) begin
            errors++; $display("FAIL midclear_busy: got %b expected 1", mem_busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            cyc = i;
            if (mem_busy !== 1'b1) break;
        end
        checks++;
        if (cyc != DEPTH) begin
            errors++; $display("FAIL restart_len: got %0d cycles expected %0d", cyc, DEPTH);
        end
        set_lane(0, LD_W, 32'h0000_0008, 32'h0, 1'b0);
        step();
        checks++;
        if (readdata_m[31:0] !== 32'h0) begin
            errors++; $display("FAIL recleared_8: got %h expected 00000000", readdata_m[31:0]);
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_conflicts();
        test_misalign();
        test_reset_midclear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
